// File: rtl/pattern_tx_pkg.sv
// pattern_tx_pkg: shared types and constants for pattern_tx_sequencer.
// Optional feature macro: PATTERN_TX_CHECKSUM_EN (adds the CHK state).
package pattern_tx_pkg;

  localparam int BYTE_CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_WAIT_DATA = 3'd2,
    S_SEND      = 3'd3,
    S_GAP       = 3'd4
`ifdef PATTERN_TX_CHECKSUM_EN
    ,S_CHK      = 3'd5
`endif
  } state_t;

  // Values every register takes in IDLE after reset.
  localparam state_t                RST_STATE    = S_IDLE;
  localparam logic                  RST_RD_EN    = 1'b0;
  localparam logic                  RST_TX_VALID = 1'b0;
  localparam logic                  RST_BUSY     = 1'b0;
  localparam logic                  RST_DONE     = 1'b0;
  localparam logic [BYTE_CNT_W-1:0] RST_BYTE_CNT = '0;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [BYTE_CNT_W-1:0] sat_inc(input logic [BYTE_CNT_W-1:0] v);
    return (v == '1) ? v : v + BYTE_CNT_W'(1);
  endfunction

endpackage

// File: rtl/pattern_tx_sequencer_gap_timer.sv
// gap_timer: loadable down-counter that times the idle gap between bytes.
// expired is high on the last gap clock, so a GAP state entered on load
// lasts exactly GAP_CYCLES clocks.
module gap_timer #(
  parameter int GAP_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expired
);

  localparam int CNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  logic [CNT_W-1:0] cnt;

  // Load the full gap length, then count down and rest at zero.
  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(GAP_CYCLES);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expired = (cnt == CNT_W'(1));

endmodule

// File: rtl/pattern_tx_sequencer.sv
// pattern_tx_sequencer: walks an inclusive, wrapping ROM address range and
// offers each byte to the UART TX over valid/ready, with an idle gap after
// every accepted byte and optional looping.
// Optional feature macro: PATTERN_TX_CHECKSUM_EN appends an XOR checksum
// byte (CHK state) after the last byte of every pass.
// All outputs are registered from the next-state values.
module pattern_tx_sequencer
  import pattern_tx_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     start_addr,
  input  logic [ADDR_W-1:0]     end_addr,
  input  logic                  loop,
  input  logic                  stop,
  output logic                  rom_rd_en,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [DATA_W-1:0]     rom_data,
  output logic [DATA_W-1:0]     tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done,
  output logic [BYTE_CNT_W-1:0] byte_cnt
);

  state_t state_q, state_d;

  logic [ADDR_W-1:0]     cur_q, cur_d, first_q, first_d, last_q, last_d;
  logic                  loop_q, loop_d, stop_q, stop_d;
  logic                  rd_en_d, tx_valid_d, busy_d, done_d;
  logic [ADDR_W-1:0]     rom_addr_d;
  logic [DATA_W-1:0]     tx_data_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_d;

  logic   handshake, in_tx, leaving_tx, accept_start;
  logic   gap_load, gap_expired, bnd_eval, stop_hit, at_end;
  logic   bnd_restart, bnd_advance, bnd_done, chk_pending;
  state_t bnd_state;

`ifdef PATTERN_TX_CHECKSUM_EN
  logic [DATA_W-1:0] xor_q, xor_d;
  logic              chk_sent_q, chk_sent_d;
  assign in_tx       = (state_q == S_SEND) || (state_q == S_CHK);
  assign chk_pending = (stop_hit || at_end) && !chk_sent_q && (state_q != S_CHK);
`else
  assign in_tx       = (state_q == S_SEND);
  assign chk_pending = 1'b0;
`endif

  assign handshake    = tx_valid && tx_ready;
  assign leaving_tx   = in_tx && handshake;
  assign accept_start = (state_q == S_IDLE) && start;
  assign stop_hit     = stop_q || stop;
  assign at_end       = (cur_q == last_q);
  assign gap_load     = leaving_tx && (GAP_CYCLES > 0);
  // The byte boundary is reached after the handshake (no gap) or after the last gap clock.
  assign bnd_eval     = (leaving_tx && (GAP_CYCLES == 0)) || ((state_q == S_GAP) && gap_expired);

  gap_timer #(
    .GAP_CYCLES(GAP_CYCLES)
  ) u_gap_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (gap_load),
    .expired(gap_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RST_STATE;
    else        state_q <= state_d;
  end

  // Next state, including the boundary decision (checksum, stop, end of range, advance).
  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    bnd_state   = S_FETCH;
    bnd_restart = 1'b0;
    bnd_advance = 1'b0;
    bnd_done    = 1'b0;
`ifdef PATTERN_TX_CHECKSUM_EN
    if (chk_pending) begin
      bnd_state = S_CHK;
    end else
`endif
    if (stop_hit) begin
      bnd_state = S_IDLE;
      bnd_done  = 1'b1;
    end else if (at_end) begin
      if (loop_q) begin
        bnd_restart = 1'b1;
      end else begin
        bnd_state = S_IDLE;
        bnd_done  = 1'b1;
      end
    end else begin
      bnd_advance = 1'b1;
    end

    case (state_q)
      S_IDLE:      if (start) state_d = S_FETCH;
      S_FETCH:     state_d = S_WAIT_DATA;
      S_WAIT_DATA: state_d = S_SEND;
      S_SEND:      if (handshake) state_d = (GAP_CYCLES > 0) ? S_GAP : bnd_state;
`ifdef PATTERN_TX_CHECKSUM_EN
      S_CHK:       if (handshake) state_d = (GAP_CYCLES > 0) ? S_GAP : bnd_state;
`endif
      S_GAP:       if (gap_expired) state_d = bnd_state;
      default:     state_d = S_IDLE;
    endcase
  end

  // Next values of the outputs and of the run context (range, cursor, stop latch).
  always_comb begin
    first_d    = first_q;
    last_d     = last_q;
    loop_d     = loop_q;
    cur_d      = cur_q;
    stop_d     = stop_q;
    rom_addr_d = rom_addr;
    tx_data_d  = tx_data;
    byte_cnt_d = byte_cnt;

    if (state_q == S_IDLE) begin
      if (start) begin
        first_d    = start_addr;
        last_d     = end_addr;
        loop_d     = loop;
        cur_d      = start_addr;
        stop_d     = 1'b0;
        byte_cnt_d = '0;
      end
    end else if (stop) begin
      stop_d = 1'b1;
    end

    if (bnd_eval && bnd_restart) cur_d = first_q;
    if (bnd_eval && bnd_advance) cur_d = cur_q + ADDR_W'(1);

    if (state_q == S_WAIT_DATA) tx_data_d = rom_data;
    if (leaving_tx) byte_cnt_d = sat_inc(byte_cnt);
    if (state_d == S_FETCH) rom_addr_d = cur_d;

`ifdef PATTERN_TX_CHECKSUM_EN
    xor_d      = xor_q;
    chk_sent_d = chk_sent_q;
    if (accept_start || (bnd_eval && bnd_restart)) xor_d = '0;
    else if ((state_q == S_SEND) && handshake)     xor_d = xor_q ^ tx_data;
    if ((state_q == S_CHK) && handshake) chk_sent_d = 1'b1;
    else if (state_d == S_FETCH)         chk_sent_d = 1'b0;
    // xor_d already folds in a byte handshaken this very cycle (no-gap case).
    if ((state_q != S_CHK) && (state_d == S_CHK)) tx_data_d = xor_d;
    tx_valid_d = (state_d == S_SEND) || (state_d == S_CHK);
`else
    tx_valid_d = (state_d == S_SEND);
`endif

    rd_en_d = (state_d == S_FETCH);
    busy_d  = (state_d != S_IDLE);
    done_d  = bnd_eval && bnd_done;
  end

  // Output and run-context registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q   <= '0;
      last_q    <= '0;
      loop_q    <= 1'b0;
      cur_q     <= '0;
      stop_q    <= 1'b0;
      rom_rd_en <= RST_RD_EN;
      rom_addr  <= '0;
      tx_data   <= '0;
      tx_valid  <= RST_TX_VALID;
      busy      <= RST_BUSY;
      done      <= RST_DONE;
      byte_cnt  <= RST_BYTE_CNT;
    end else begin
      first_q   <= first_d;
      last_q    <= last_d;
      loop_q    <= loop_d;
      cur_q     <= cur_d;
      stop_q    <= stop_d;
      rom_rd_en <= rd_en_d;
      rom_addr  <= rom_addr_d;
      tx_data   <= tx_data_d;
      tx_valid  <= tx_valid_d;
      busy      <= busy_d;
      done      <= done_d;
      byte_cnt  <= byte_cnt_d;
    end
  end

`ifdef PATTERN_TX_CHECKSUM_EN
  // Checksum accumulator and the per-pass "checksum already sent" flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xor_q      <= '0;
      chk_sent_q <= 1'b0;
    end else begin
      xor_q      <= xor_d;
      chk_sent_q <= chk_sent_d;
    end
  end
`endif

endmodule

// File: tb/tb_pattern_tx_sequencer.sv
// tb_pattern_tx_sequencer: self-checking bench for pattern_tx_sequencer.
// Expected byte streams come from a list-walking model of the address range
// (plus an XOR checksum per pass when PATTERN_TX_CHECKSUM_EN is defined).
module tb_pattern_tx_sequencer;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int GAP    = 4;
  localparam int DEPTH  = 32;
`ifdef PATTERN_TX_CHECKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0, loop = 1'b0, stop = 1'b0;
  logic              tx_ready = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0, end_addr = '0;
  logic              rom_rd_en, tx_valid, busy, done;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data = '0, tx_data;
  logic [15:0]       byte_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int rdy_mode = 0;  // 0: ready low, 1: ready high, 2: random

  logic [7:0] rom [DEPTH];

  logic [7:0] got_data[$];
  int         got_cyc[$];
  int         done_cyc[$];
  int         rd_addr[$];
  int         stall_err = 0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  logic [7:0] exp_data[$];
  bit         exp_chk[$];
  int         exp_addr[$];

  pattern_tx_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .end_addr(end_addr), .loop(loop), .stop(stop), .rom_rd_en(rom_rd_en),
    .rom_addr(rom_addr), .rom_data(rom_data), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done),
    .byte_cnt(byte_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data valid the clock after the read strobe.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rom_rd_en) rom_data <= rom[rom_addr];
  end

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 2) tx_ready = 1'($urandom_range(0, 1));
    else               tx_ready = (rdy_mode == 1);
  end

  // Monitor on the falling edge: accepted bytes, done pulses, ROM reads, stall stability.
  always @(negedge clk) begin
    if (tx_valid && tx_ready) begin
      got_data.push_back(tx_data);
      got_cyc.push_back(cyc);
    end
    if (done) done_cyc.push_back(cyc);
    if (rom_rd_en) rd_addr.push_back(int'(rom_addr));
    if (rst_n && prev_stall && (!tx_valid || tx_data !== prev_data)) stall_err++;
    prev_stall = rst_n && tx_valid && !tx_ready;
    prev_data  = tx_data;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input int m);
    rdy_mode = m;
    tick();
    tick();
  endtask

  task automatic clear_mon();
    got_data.delete(); got_cyc.delete(); done_cyc.delete(); rd_addr.delete();
    stall_err = 0;
  endtask

  // Reference: walk s..e (wrapping mod DEPTH) for the given number of passes.
  task automatic build_exp(input int s, input int e, input int passes);
    exp_data.delete(); exp_chk.delete(); exp_addr.delete();
    for (int p = 0; p < passes; p++) begin
      int a = s;
      logic [7:0] x = 8'h00;
      for (int n = 0; n < DEPTH; n++) begin
        exp_addr.push_back(a);
        exp_data.push_back(rom[a]);
        exp_chk.push_back(1'b0);
        x ^= rom[a];
        if (a == e) break;
        a = (a + 1) % DEPTH;
      end
      if (CHK != 0) begin
        exp_data.push_back(x);
        exp_chk.push_back(1'b1);
      end
    end
  endtask

  task automatic start_run(input int s, input int e, input bit l, input bit st, output int p);
    start_addr = ADDR_W'(s);
    end_addr   = ADDR_W'(e);
    loop       = l;
    stop       = st;
    start      = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    p     = cyc;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_cyc.size() != 0) begin
        ok = 1'b1;
        break;
      end
    end
    for (int i = 0; i < GAP + 4; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_cmp++;
    if (rom_rd_en !== 1'b0 || rom_addr !== '0 || tx_data !== '0 || tx_valid !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || byte_cnt !== 16'h0) begin
      n_err++;
      $display("FAIL reset_values: rd_en=%b addr=%0d data=%0h valid=%b busy=%b done=%b cnt=%0d, want all 0",
               rom_rd_en, rom_addr, tx_data, tx_valid, busy, done, byte_cnt);
    end
    rst_n = 1'b1;
    tick();
    clear_mon();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick(); tick();
    n_cmp++;
    if (busy !== 1'b0 || rd_addr.size() != 0 || done_cyc.size() != 0) begin
      n_err++;
      $display("FAIL idle_stop_ignored: busy=%b reads=%0d dones=%0d, want 0/0/0",
               busy, rd_addr.size(), done_cyc.size());
    end
  endtask

  task automatic test_basic();
    int p, exp_c;
    bit ok;
    set_ready(1);
    clear_mon();
    build_exp(0, 3, 1);
    start_run(0, 3, 1'b0, 1'b0, p);
    n_cmp++;
    if (rom_rd_en !== 1'b1 || rom_addr !== 5'd0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL basic_latency: rd_en=%b addr=%0d busy=%b, want 1/0/1", rom_rd_en, rom_addr, busy);
    end
    wait_done(400, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL basic_done_timeout: no done, want done"); end
    n_cmp++;
    if (got_data.size() != exp_data.size()) begin
      n_err++;
      $display("FAIL basic_count: got %0d bytes, want %0d", got_data.size(), exp_data.size());
    end else begin
      exp_c = p + 2;
      for (int k = 0; k < exp_data.size(); k++) begin
        if (k > 0) exp_c += exp_chk[k] ? (1 + GAP) : (3 + GAP);
        n_cmp++;
        if (got_data[k] !== exp_data[k] || got_cyc[k] != exp_c) begin
          n_err++;
          $display("FAIL basic_byte%0d: got %0h@%0d, want %0h@%0d", k, got_data[k], got_cyc[k], exp_data[k], exp_c);
        end
      end
      n_cmp++;
      if (done_cyc.size() != 1 || done_cyc[0] != exp_c + GAP + 1) begin
        n_err++;
        $display("FAIL basic_done: got %0d pulses first@%0d, want 1@%0d",
                 done_cyc.size(), (done_cyc.size() != 0) ? done_cyc[0] : -1, exp_c + GAP + 1);
      end
    end
    n_cmp++;
    if (byte_cnt !== 16'(exp_data.size()) || busy !== 1'b0) begin
      n_err++;
      $display("FAIL basic_cnt: cnt=%0d busy=%b, want %0d/0", byte_cnt, busy, exp_data.size());
    end
  endtask

  task automatic test_wrap();
    int p;
    bit ok;
    clear_mon();
    build_exp(30, 1, 1);
    start_run(30, 1, 1'b0, 1'b0, p);
    wait_done(400, ok);
    n_cmp++;
    if (!ok || rd_addr.size() != exp_addr.size()) begin
      n_err++;
      $display("FAIL wrap_reads: done=%b reads=%0d, want 1/%0d", ok, rd_addr.size(), exp_addr.size());
    end else begin
      for (int k = 0; k < exp_addr.size(); k++) begin
        n_cmp++;
        if (rd_addr[k] != exp_addr[k]) begin
          n_err++;
          $display("FAIL wrap_addr%0d: got %0d, want %0d", k, rd_addr[k], exp_addr[k]);
        end
      end
    end
    n_cmp++;
    if (got_data != exp_data) begin
      n_err++;
      $display("FAIL wrap_bytes: got %p, want %p", got_data, exp_data);
    end
  endtask

  task automatic test_stall();
    int p;
    bit ok;
    set_ready(0);
    clear_mon();
    build_exp(9, 9, 1);
    start_run(9, 9, 1'b0, 1'b0, p);
    for (int i = 0; i < 10 && !tx_valid; i++) tick();
    for (int i = 0; i < 10; i++) tick();
    n_cmp++;
    if (tx_valid !== 1'b1 || tx_data !== rom[9] || got_data.size() != 0) begin
      n_err++;
      $display("FAIL stall_hold: valid=%b data=%0h accepted=%0d, want 1/%0h/0",
               tx_valid, tx_data, got_data.size(), rom[9]);
    end
    rdy_mode = 1;
    wait_done(200, ok);
    n_cmp++;
    if (!ok || got_data != exp_data || stall_err != 0 || byte_cnt !== 16'(exp_data.size())) begin
      n_err++;
      $display("FAIL stall_result: done=%b bytes=%p stall_err=%0d cnt=%0d, want 1/%p/0/%0d",
               ok, got_data, stall_err, byte_cnt, exp_data, exp_data.size());
    end
  endtask

  task automatic test_loop_stop();
    int p, n_wait, reads;
    bit ok;
    set_ready(1);
    clear_mon();
    build_exp(5, 6, 2);
    n_wait = 2 * (2 + CHK) - CHK;
    start_run(5, 6, 1'b1, 1'b0, p);
    for (int i = 0; i < 400 && got_data.size() < n_wait; i++) tick();
    // Now in the gap that follows address 6 of the second pass.
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done(200, ok);
    n_cmp++;
    if (!ok || got_data != exp_data || done_cyc.size() != 1) begin
      n_err++;
      $display("FAIL loop_stop_bytes: done=%b bytes=%p dones=%0d, want 1/%p/1",
               ok, got_data, done_cyc.size(), exp_data);
    end
    reads = rd_addr.size();
    for (int i = 0; i < 20; i++) tick();
    n_cmp++;
    if (rd_addr.size() != 4 || reads != 4 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL loop_stop_quiet: reads=%0d->%0d busy=%b, want 4->4/0", reads, rd_addr.size(), busy);
    end
  endtask

  task automatic test_start_stop_idle();
    int p;
    bit ok;
    clear_mon();
    build_exp(2, 4, 1);
    start_run(2, 4, 1'b0, 1'b1, p);
    for (int i = 0; i < 5; i++) tick();
    start_addr = 5'd20;
    end_addr   = 5'd21;
    start      = 1'b1;
    tick();
    start = 1'b0;
    wait_done(400, ok);
    n_cmp++;
    if (!ok || got_data != exp_data || rd_addr != exp_addr || done_cyc.size() != 1) begin
      n_err++;
      $display("FAIL start_wins_busy_ignored: done=%b bytes=%p reads=%p, want 1/%p/%p",
               ok, got_data, rd_addr, exp_data, exp_addr);
    end
  endtask

  task automatic test_async_reset();
    int p;
    bit ok;
    set_ready(0);
    clear_mon();
    start_run(10, 12, 1'b0, 1'b0, p);
    for (int i = 0; i < 10 && !tx_valid; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || byte_cnt !== 16'h0) begin
      n_err++;
      $display("FAIL async_reset: valid=%b busy=%b done=%b cnt=%0d, want 0/0/0/0", tx_valid, busy, done, byte_cnt);
    end
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    n_cmp++;
    if (done_cyc.size() != 0) begin
      n_err++;
      $display("FAIL async_reset_done: got %0d done pulses, want 0", done_cyc.size());
    end
    set_ready(1);
    clear_mon();
    build_exp(0, 3, 1);
    start_run(0, 3, 1'b0, 1'b0, p);
    wait_done(400, ok);
    n_cmp++;
    if (!ok || got_data != exp_data || byte_cnt !== 16'(exp_data.size())) begin
      n_err++;
      $display("FAIL async_reset_rerun: done=%b bytes=%p cnt=%0d, want 1/%p/%0d",
               ok, got_data, byte_cnt, exp_data, exp_data.size());
    end
  endtask

  task automatic test_random();
    int p, s, e;
    bit ok;
    set_ready(2);
    for (int r = 0; r < 6; r++) begin
      s = $urandom_range(0, DEPTH - 1);
      e = $urandom_range(0, DEPTH - 1);
      clear_mon();
      build_exp(s, e, 1);
      start_run(s, e, 1'b0, 1'b0, p);
      wait_done(2000, ok);
      n_cmp++;
      if (!ok || got_data != exp_data || stall_err != 0 || done_cyc.size() != 1 ||
          byte_cnt !== 16'(exp_data.size())) begin
        n_err++;
        $display("FAIL random_run%0d (%0d..%0d): done=%b n=%0d stall_err=%0d dones=%0d cnt=%0d, want 1/%0d/0/1/%0d",
                 r, s, e, ok, got_data.size(), stall_err, done_cyc.size(), byte_cnt,
                 exp_data.size(), exp_data.size());
      end
    end
    set_ready(1);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = 8'($urandom);
    rom[0] = 8'h00; rom[1] = 8'h01; rom[2] = 8'h02; rom[3] = 8'h04;
    rom[5] = 8'h10; rom[6] = 8'h20; rom[30] = 8'hAA; rom[31] = 8'h55;
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_loop_stop();
    test_start_stop_idle();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pattern_tx_sequencer.md
# pattern_tx_sequencer

- Controller that sequences the byte-pattern ROM into the UART transmitter.
- On a start request it walks an inclusive ROM address range, issuing one synchronous read per byte and offering each byte to the transmitter over a valid/ready handshake.
- It inserts a programmable idle gap between bytes and can loop the range continuously.
- It sits between the pattern ROM (as its only reader) and the UART TX front end.

## Interface
Parameters:
- ADDR_W, 5, ROM address width; the range wraps modulo 2^ADDR_W.
- DATA_W, 8, byte width.
- GAP_CYCLES, 16, idle clocks after each accepted byte; 0 disables the gap.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a run; sampled only in IDLE.
- start_addr  in  ADDR_W  first address; latched on accepted start.
- end_addr  in  ADDR_W  last address, inclusive; latched on accepted start.
- loop  in  1  repeat the range; latched on accepted start.
- stop  in  1  request termination at the next byte boundary; level or pulse.
- rom_rd_en  out  1  ROM read strobe.
- rom_addr  out  ADDR_W  ROM address.
- rom_data  in  DATA_W  ROM output, valid exactly 1 clock after rom_rd_en.
- tx_data  out  DATA_W  byte offered to the UART.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  UART accepts the byte when tx_valid && tx_ready.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-clock pulse when a run ends.
- byte_cnt  out  16  bytes accepted in the current run; saturates at 0xFFFF.

## Operation
States: IDLE, FETCH, WAIT_DATA, SEND, GAP (+ CHK when the checksum is compiled in).

- **IDLE**
  - start=1 latches start_addr, end_addr and loop.
  - Sets cur=start_addr, clears byte_cnt and the stop latch, then goes to FETCH.
- **FETCH**
  - rom_rd_en=1 and rom_addr=cur for exactly one clock.
  - Next state is WAIT_DATA.
- **WAIT_DATA**
  - Captures rom_data into tx_data.
  - Next state is SEND.
- **SEND**
  - tx_valid=1 and tx_data is held stable until the handshake.
  - On handshake: byte_cnt++.
  - If GAP_CYCLES>0, go to GAP; otherwise evaluate the boundary.
- **GAP**
  - Counts GAP_CYCLES clocks, then evaluates the boundary.
- **Boundary evaluation**
  - If the stop latch is set: done, go to IDLE.
  - Else if cur==end_addr:
    - loop=1: cur=start_addr, go to FETCH.
    - loop=0: done, go to IDLE.
  - Else cur=cur+1 modulo 2^ADDR_W, go to FETCH.
- **Address range**
  - end_addr<start_addr wraps through the top of the address space. Example: 30→31→0→1 with start=30, end=1.
  - start_addr==end_addr sends exactly one byte per pass.
- **stop handling**
  - stop is latched in any non-IDLE state.
  - A byte already in SEND is never withdrawn: tx_valid does not drop without a handshake.
  - stop in IDLE is ignored.
- **Simultaneous events**
  - start while busy is ignored.
  - stop and start in the same IDLE cycle: start wins and stop is ignored.

## Timing
- Reset values: rom_rd_en=0, rom_addr=0, tx_data=0, tx_valid=0, busy=0, done=0, byte_cnt=0, state=IDLE, gap counter=0.
- rst_n low mid-run aborts immediately. No done pulse is generated, and tx_valid drops asynchronously.
- Latencies:
  - start accepted at edge N → rom_rd_en high in cycle N+1.
  - tx_valid rises at N+3.
  - Minimum byte period with tx_ready held high: 3 + GAP_CYCLES clocks.
- done is asserted in the cycle after the last handshake (or after the final GAP clock). busy falls in the same cycle that done pulses.
- All outputs are registered.

## Configuration
- PATTERN_TX_CHECKSUM_EN defined:
  - After the final byte of each pass (cur==end_addr, or the stop boundary), the block enters CHK.
  - CHK sends one extra byte: the XOR of all bytes accepted in that pass, using the same handshake followed by a gap.
  - Loop or termination is decided after CHK.
  - byte_cnt counts the checksum byte.
- Undefined: CHK state, XOR accumulator and the extra byte are absent.

## Structure
- pattern_tx_pkg holds:
  - the state enum;
  - the byte_cnt width constant (16);
  - the IDLE-state reset constants.
- One sub-module, gap_timer: a GAP_CYCLES down-counter with a load input and an expired output, instantiated once.

## Test plan
- start_addr=0, end_addr=3, loop=0, GAP_CYCLES=0, tx_ready=1 → bytes 0x00,0x01,0x02,0x04 on consecutive 3-clock periods; one done pulse; byte_cnt=4.
- start=30, end=1, loop=0 → addresses 30,31,0,1 read in order; bytes 0xAA,0x55,0x00,0x01.
- tx_ready held low 10 clocks during SEND → tx_valid and tx_data stable throughout; exactly one byte accepted.
- loop=1, range 5..6, stop pulsed while address 6 is in GAP → pattern 0x10,0x20,0x10,0x20… ends after the in-flight byte; done pulses; no further rom_rd_en.
- rst_n asserted while in SEND → tx_valid=0 and busy=0 immediately; no done; a fresh start after release runs normally.
- PATTERN_TX_CHECKSUM_EN, range 1..3 → 0x01,0x02,0x04, then checksum 0x07; byte_cnt=4.
